mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the next-generation datapath and consumes the GRF RD1/RD2 operands.
- Models fixed multi-cycle latency with a busy handshake so the controller can stall dependent mfhi/mflo and back-to-back mult/div.
- Generalises width and latencies and adds signed/unsigned modes and direct HI/LO writes.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; legal range >= 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range >= 1.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle request strobe, sampled at the rising edge.
- op, input, 3, operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are reserved.
- A, input, WIDTH, operand A (GRF RD1).
- B, input, WIDTH, operand B (GRF RD2).
- busy, output, 1, high while a mult/div is in flight.
- stall_req, output, 1, combinational: busy OR (start AND op in {0..3}).
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- Reset (reset low, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result registers=0. Reset takes effect immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE and RUN.
- IDLE, start=1, op MULT/MULTU at edge k:
  - latch {prod_hi, prod_lo} = A*B as a 2*WIDTH-bit product, signed for MULT, unsigned for MULTU.
  - load counter = MULT_CYCLES; go to RUN.
  - busy=1 in cycles k+1 .. k+MULT_CYCLES.
- IDLE, start=1, op DIV/DIVU: same as multiply, with latched quotient/remainder and counter = DIV_CYCLES.
  - DIV: quotient truncates toward zero; remainder takes the sign of A.
  - DIVU: unsigned quotient and remainder.
- RUN: counter decrements each edge. At the edge where counter goes 1 -> 0:
  - hi <= pending upper half or remainder; lo <= pending lower half or quotient.
  - busy <= 0; return to IDLE. New hi/lo are visible in the first cycle busy is low.
- MTHI/MTLO with start=1 in IDLE: hi (or lo) <= A at that edge; busy stays 0; no latency.
- start=1 while busy=1: ignored for every op, including MTHI/MTLO; the controller must hold the instruction via stall_req. HI/LO are never corrupted by an ignored request.
- Reserved op (6, 7) with start=1: no effect, busy stays 0.
- Divide by zero (B=0) for DIV/DIVU: the full DIV_CYCLES busy period still occurs; hi and lo keep their prior values at completion.
- Signed overflow, DIV with A=most-negative and B=-1: lo=most-negative, hi=0 (two's-complement wrap, no exception).
- Back-to-back: a start in the same cycle busy falls is seen while busy=0 and is accepted. Minimum gap between mult/div completion and the next acceptance is therefore 0 cycles.
- hi and lo are plain register outputs; no combinational path from A/B.

Decomposition:
- Shared package mdu_pkg holds:
  - op code localparams (OP_MULT..OP_MTLO);
  - state encoding (S_IDLE, S_RUN);
  - a width-check helper for CNT_W.
- One combinational sub-module, mdu_arith (WIDTH parameter):
  - inputs: A, B, op;
  - outputs: res_hi, res_lo, div_zero;
  - contains signed/unsigned multiply and the divide/remainder rules above.
- mdu_unit owns the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset then MULT A=32'hFFFFFFFE (-2), B=3: stall_req=1 on the start cycle; busy=1 for exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- MULTU A=32'hFFFFFFFF, B=32'hFFFFFFFF: after 5 busy cycles, hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV A=-7, B=2: busy for 10 cycles; lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). Follow with DIVU A=7, B=0: 10 busy cycles, then hi/lo unchanged from the DIV result.
- MTHI A=32'h12345678 issued mid-MULT (busy=1): ignored, and the final hi is the product. MTLO A=32'hCAFEBABE in IDLE: lo updates at the next edge, busy stays 0.
- Start MULT, drive reset low on the 3rd busy cycle: busy, hi and lo read 0 immediately (asynchronous). After release, a DIV A=32'h80000000, B=32'hFFFFFFFF gives lo=32'h80000000, hi=0.
- Re-instantiate with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3: MULT 16'h8000 x 16'h0002 gives hi=16'hFFFF, lo=16'h0000 after one busy cycle. A new start accepted on the busy-falling cycle completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// an elaboration-time parameter sanity helper.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // True when both latencies are legal and fit in a CNT_W-bit down-counter.
    function automatic bit cnt_w_ok(input int cnt_w, input int mult_cycles,
                                    input int div_cycles);
        int max_c;
        max_c = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        if (mult_cycles < 1 || div_cycles < 1 || cnt_w < 1) return 1'b0;
        if (cnt_w >= 31) return 1'b1;
        return (1 << cnt_w) > max_c;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: signed/unsigned product, and
// quotient/remainder with truncate-toward-zero semantics.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               neg_a, neg_b, b_zero;
    logic [WIDTH-1:0]   abs_a, abs_b, abs_b_safe, b_safe;
    logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Low 2*WIDTH bits of the product of sign-extended operands are the signed product.
    assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    assign neg_a      = A[WIDTH-1];
    assign neg_b      = B[WIDTH-1];
    assign b_zero     = (B == '0);
    assign abs_a      = neg_a ? -A : A;
    assign abs_b      = neg_b ? -B : B;
    // Divide by zero result is discarded; a safe divisor keeps the datapath X-free.
    assign abs_b_safe = b_zero ? WIDTH'(1) : abs_b;
    assign b_safe     = b_zero ? WIDTH'(1) : B;

    // Magnitude divide then re-sign: most-negative / -1 wraps back to most-negative.
    assign q_mag = abs_a / abs_b_safe;
    assign r_mag = abs_a % abs_b_safe;
    assign q_s   = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign r_s   = neg_a ? -r_mag : r_mag;
    assign q_u   = A / b_safe;
    assign r_u   = A % b_safe;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        div_zero = 1'b0;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi   = r_s;
                res_lo   = q_s;
                div_zero = b_zero;
            end
            OP_DIVU: begin
                res_hi   = r_u;
                res_lo   = q_u;
                div_zero = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and a
// busy/stall handshake for the pipeline controller.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam bit CFG_OK = cnt_w_ok(CNT_W, MULT_CYCLES, DIV_CYCLES);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] pend_hi_q, pend_lo_q, hi_q, lo_q;
    logic             pend_wr_q, busy_q;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             div_zero, is_muldiv;

    assign is_muldiv = (op <= OP_DIVU);
    assign busy      = busy_q;
    assign stall_req = busy_q | (start & is_muldiv);
    assign hi        = hi_q;
    assign lo        = lo_q;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op       (op),
        .A        (A),
        .B        (B),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the pending result registers are reset too so
    // a cleared unit never exposes stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_muldiv) begin
                            pend_hi_q <= res_hi;
                            pend_lo_q <= res_lo;
                            pend_wr_q <= ~div_zero;
                            cnt_q     <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            busy_q    <= 1'b1;
                            state_q   <= S_RUN;
                        end else if (op == OP_MTHI) begin
                            hi_q <= A;
                        end else if (op == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    cfg_ok_a: assert property (@(posedge clk) CFG_OK);

endmodule
